// File: rtl/bsg_saf_packet_arbiter.sv
// Packet-granular round-robin arbiter in front of a store-and-forward ingress.
// One requester holds the grant from arbitration until its last beat handshakes,
// so downstream never sees interleaved packets. A one-cycle IDLE bubble separates
// consecutive packets; that cycle is where the next winner is chosen.

module bsg_saf_packet_arbiter #(
  parameter int unsigned width_p       = 64,
  parameter int unsigned els_p         = 2,
  parameter int unsigned count_width_p = 16
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,

  input  logic [els_p*width_p-1:0]   data_i,
  input  logic [els_p-1:0]           v_i,
  input  logic [els_p-1:0]           last_i,
  input  logic [els_p-1:0]           error_i,
  output logic [els_p-1:0]           ready_and_o,

  output logic [width_p-1:0]         data_o,
  output logic                       v_o,
  output logic                       last_o,
  output logic                       error_o,
  input  logic                       ready_and_i,

  output logic [els_p-1:0]           grant_o,
  output logic                       busy_o,
  output logic [count_width_p-1:0]   pkt_count_o
);

  localparam int unsigned IdxW = (els_p > 1) ? $clog2(els_p) : 1;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StBusy = 1'b1;

  // Registered state
  logic [0:0]               r_state;
  logic [els_p-1:0]         r_grant;
  logic [IdxW-1:0]          r_grant_idx;
  logic [IdxW-1:0]          r_rr_ptr;
  logic [count_width_p-1:0] r_pkt_count;

  // Next-state values
  logic [0:0]               w_state_next;
  logic [els_p-1:0]         w_grant_next;
  logic [IdxW-1:0]          w_grant_idx_next;
  logic [IdxW-1:0]          w_rr_ptr_next;
  logic [count_width_p-1:0] w_pkt_count_next;

  // Arbitration
  int unsigned              w_cand;
  logic [IdxW-1:0]          w_cand_idx;
  logic                     w_sel_found;
  logic [IdxW-1:0]          w_sel_idx;
  logic [els_p-1:0]         w_sel_onehot;

  // Downstream handshake of the final beat of the granted packet
  logic                     w_xfer_last;

  // Round-robin search: first valid requester strictly after the last one served.
  always_comb begin
    w_cand       = 0;
    w_cand_idx   = '0;
    w_sel_found  = 1'b0;
    w_sel_idx    = '0;
    w_sel_onehot = '0;
    for (int unsigned i = 1; i <= els_p; i++) begin
      w_cand     = (32'(r_rr_ptr) + i) % els_p;
      w_cand_idx = IdxW'(w_cand);
      if (!w_sel_found && v_i[w_cand_idx]) begin
        w_sel_found = 1'b1;
        w_sel_idx   = w_cand_idx;
      end
    end
    w_sel_onehot[w_sel_idx] = w_sel_found;
  end

  // Downstream mux: only the granted requester is visible, and only while BUSY.
  always_comb begin
    data_o      = '0;
    v_o         = 1'b0;
    last_o      = 1'b0;
    error_o     = 1'b0;
    ready_and_o = '0;
    if (r_state == StBusy) begin
      data_o                   = data_i[32'(r_grant_idx) * width_p +: width_p];
      v_o                      = v_i[r_grant_idx];
      last_o                   = last_i[r_grant_idx] & v_i[r_grant_idx];
      error_o                  = error_i[r_grant_idx] & v_i[r_grant_idx];
      ready_and_o[r_grant_idx] = ready_and_i;
    end
  end

  assign w_xfer_last = v_o & ready_and_i & last_o;

  // FSM next state: pick a winner in IDLE, release it on the handshaked last beat.
  always_comb begin
    w_state_next     = r_state;
    w_grant_next     = r_grant;
    w_grant_idx_next = r_grant_idx;
    w_rr_ptr_next    = r_rr_ptr;
    w_pkt_count_next = r_pkt_count;
    unique case (r_state)
      StIdle: begin
        if (w_sel_found) begin
          w_state_next     = StBusy;
          w_grant_next     = w_sel_onehot;
          w_grant_idx_next = w_sel_idx;
        end
      end
      StBusy: begin
        if (w_xfer_last) begin
          w_state_next  = StIdle;
          w_grant_next  = '0;
          w_rr_ptr_next = r_grant_idx;
          // Saturate rather than wrap so status software never sees a rollback.
          if (r_pkt_count != {count_width_p{1'b1}}) begin
            w_pkt_count_next = r_pkt_count + 1'b1;
          end
        end
      end
      default: begin
        w_state_next = StIdle;
        w_grant_next = '0;
      end
    endcase
  end

  // State registers; reset leaves rr_ptr at the top so requester 0 wins first.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state     <= StIdle;
      r_grant     <= '0;
      r_grant_idx <= '0;
      r_rr_ptr    <= IdxW'(els_p - 1);
      r_pkt_count <= '0;
    end else begin
      r_state     <= w_state_next;
      r_grant     <= w_grant_next;
      r_grant_idx <= w_grant_idx_next;
      r_rr_ptr    <= w_rr_ptr_next;
      r_pkt_count <= w_pkt_count_next;
    end
  end

  assign grant_o     = r_grant;
  assign busy_o      = (r_state == StBusy);
  assign pkt_count_o = r_pkt_count;

`ifndef SYNTHESIS
  // Grant is one-hot exactly while BUSY and zero while IDLE.
  a_grant_onehot: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (r_state == StBusy) |-> $onehot(r_grant));
  a_grant_idle_zero: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (r_state == StIdle) |-> (r_grant == '0));
  // No grant change mid-packet.
  a_grant_hold: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (r_state == StBusy && !w_xfer_last) |=> $stable(r_grant));
`endif

endmodule

// File: doc/bsg_saf_packet_arbiter.md
Name: bsg_saf_packet_arbiter

Overview:
- Packet-granular round-robin arbiter sharing one store-and-forward ingress between els_p upstream packet streams, for example the MAC TX path fed by several DMA or host queues.
- Grants one requester at a time and holds the grant until that packet's last beat has handshaked, so packets are never interleaved downstream.
- Passes the per-beat error flag through so the downstream store-and-forward can drop bad frames.
- Reports grant, busy and a packet count for status registers.

Parameters:
- width_p, 64: data beat width in bits.
- els_p, 2: number of requesters; legal range 2..8.
- count_width_p, 16: width of the forwarded-packet counter.

Ports:
- clk_i  in  1  single clock.
- reset_n_i  in  1  asynchronous, active-low reset.
- data_i  in  els_p*width_p  per-requester beat; requester k occupies bits [k*width_p +: width_p].
- v_i  in  els_p  per-requester beat valid.
- last_i  in  els_p  per-requester last beat of packet.
- error_i  in  els_p  per-requester beat error.
- ready_and_o  out  els_p  per-requester ready.
- data_o  out  width_p  beat to store-and-forward.
- v_o  out  1  downstream valid.
- last_o  out  1  downstream last.
- error_o  out  1  downstream error.
- ready_and_i  in  1  downstream ready.
- grant_o  out  els_p  one-hot current grant; all-zero when idle.
- busy_o  out  1  a packet is in flight.
- pkt_count_o  out  count_width_p  packets forwarded since reset.

Behaviour:
- The reset is asynchronous and active-low. While reset_n_i=0, every state register clears immediately:
  - state=IDLE, grant=0, pkt_count=0, rr_ptr=els_p-1, so requester 0 wins the first arbitration.
  - All outputs are 0, including ready_and_o.
- A reset asserted mid-packet truncates that packet with no last beat. The downstream block's own reset clears its partial frame.
- FSM with two states, IDLE and BUSY.
- IDLE:
  - If any v_i bit is set, select the first set bit searching upward from rr_ptr+1, modulo els_p.
  - Register the selection as a one-hot grant and go to BUSY next cycle.
  - No beat transfers in IDLE: v_o=0 and ready_and_o=0.
  - Arbitration latency is 1 cycle from v_i to the first possible beat.
- BUSY, with g the granted index:
  - data_o = data_i[g], v_o = v_i[g], last_o = last_i[g] & v_i[g], error_o = error_i[g] & v_i[g]. These are combinational from the granted inputs.
  - ready_and_o[g] = ready_and_i. Every other ready_and_o bit is 0.
  - A beat transfers when v_o & ready_and_i.
  - On a transfer with last_o=1, all of the following happen together:
    - Go to IDLE.
    - rr_ptr <= g.
    - grant clears.
    - pkt_count_o increments (error packets included).
  - Net cost: one bubble cycle between consecutive packets.
- Stability rules:
  - The grant never changes while BUSY, whatever other v_i bits do.
  - v_i[g] deasserting mid-packet just stalls; the grant is held.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,els_p-1,0. No requester waits more than els_p-1 packets.
- pkt_count_o saturates at all-ones and does not wrap.
- busy_o = (state==BUSY). grant_o is the registered grant.
- A single-beat packet (last on its first beat) is legal: BUSY lasts exactly 1 cycle when ready_and_i=1.
- Simultaneous new requests arriving during BUSY are only sampled in the next IDLE.

Test Plan:
- Requester 0 only, one 4-beat packet, ready_and_i=1 → v_o high 4 cycles after a 1-cycle IDLE; last_o on beat 4; pkt_count_o=1; grant_o 01 → 00.
- Both requesters continuously valid, 2-beat packets ×6 → grant order 0,1,0,1,0,1; beats never interleave; pkt_count_o=6.
- Requester 1 packet in flight, requester 0 raises v_i mid-packet, ready_and_i toggling 1,0,1 → grant stays 10 until requester 1's last handshakes; ready_and_o[0]=0 throughout; then requester 0 is served.
- Single-beat packet with error_i=1 → error_o=1 and last_o=1 in the same cycle; counter increments; the next arbitration proceeds normally.
- Assert reset_n_i=0 asynchronously on beat 2 of 5 → outputs go 0 immediately without waiting for a clock edge; after release, requester 0 wins the first arbitration; pkt_count_o=0.
- count_width_p=2, 5 packets → pkt_count_o reads 1,2,3,3,3.
